// File: rtl/vdp_text.sv
// Text-mode video pipeline: per 8-dot cell fetches code/glyph/attr from VRAM, then serialises
// pixels through a fixed RGB444 palette one cell later. Optional blinking cursor: CURSOR_EN.
module vdp_text #(
  parameter int ADDR_W = 16,
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int FONT_H = 8,
  parameter int LINE_SHIFT = 1,
  parameter logic [ADDR_W-1:0] TEXT_BASE = 'h6000,
  parameter logic [ADDR_W-1:0] ATTR_BASE = 'h7000,
  parameter logic [ADDR_W-1:0] FONT_BASE = 'h3000
`ifdef CURSOR_EN
  , parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [9:0]        column_i,
  input  logic [9:0]        line_i,
  input  logic              in_visible_i,
  input  logic              in_hsync_i,
  input  logic              in_vsync_i,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic              vram_rd_o,
  input  logic [7:0]        vram_data_i,
  output logic [3:0]        r_o,
  output logic [3:0]        g_o,
  output logic [3:0]        b_o,
  output logic              hsync_o,
  output logic              vsync_o
`ifdef CURSOR_EN
  , input logic [6:0]       cursor_col_i,
  input  logic [4:0]        cursor_row_i
`endif
);

  localparam int FSH = $clog2(FONT_H);

  function automatic logic [11:0] palette(input logic [3:0] idx);
    palette = 12'h000;
    case (idx)
      4'h0: palette = 12'h000;  4'h1: palette = 12'h00A;
      4'h2: palette = 12'h0A0;  4'h3: palette = 12'h0AA;
      4'h4: palette = 12'hA00;  4'h5: palette = 12'hA0A;
      4'h6: palette = 12'hA50;  4'h7: palette = 12'hAAA;
      4'h8: palette = 12'h555;  4'h9: palette = 12'h55F;
      4'hA: palette = 12'h5F5;  4'hB: palette = 12'h5FF;
      4'hC: palette = 12'hF55;  4'hD: palette = 12'hF5F;
      4'hE: palette = 12'hFF5;  4'hF: palette = 12'hFFF;
      default: palette = 12'h000;
    endcase
  endfunction

  logic [2:0]        dot;
  logic [6:0]        cell_col;
  logic [9:0]        scan, cell_row;
  logic [3:0]        grow;
  logic [ADDR_W-1:0] cell_off;
  logic              in_range;

  assign dot      = column_i[2:0];
  assign cell_col = column_i[9:3];
  assign scan     = line_i >> LINE_SHIFT;
  assign cell_row = scan >> FSH;
  assign grow     = 4'(scan & 10'(FONT_H - 1));
  assign cell_off = ADDR_W'(32'(cell_row) * COLS + 32'(cell_col));
  assign in_range = (32'(cell_col) < COLS) && (32'(cell_row) < ROWS);

  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d, f_off_q;
  logic              vram_rd_q, vram_rd_d;
  logic [3:0]        f_grow_q;
  logic              f_vis_q, f_hs_q, f_vs_q, f_range_q;
  logic [7:0]        f_glyph_q, f_attr_q, d_glyph_q, d_attr_q;
  logic              d_vis_q, d_hs_q, d_vs_q;
  logic [11:0]       rgb_q, rgb_d;
  logic              hs_q, vs_q;
  logic [3:0]        fg_idx, bg_idx;

  // The glyph request is built from the code byte on the bus, so no code register is needed.
  always_comb begin
    vram_addr_d = vram_addr_q;
    vram_rd_d   = 1'b0;
    case (dot)
      3'd0: begin vram_addr_d = TEXT_BASE + cell_off; vram_rd_d = 1'b1; end
      3'd2: begin
        vram_addr_d = FONT_BASE + ADDR_W'(32'(vram_data_i) * FONT_H + 32'(f_grow_q));
        vram_rd_d   = 1'b1;
      end
      3'd4: begin vram_addr_d = ATTR_BASE + f_off_q; vram_rd_d = 1'b1; end
      default: ;
    endcase
  end

`ifdef CURSOR_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic          f_curs_q, d_curs_q, vs_prev_q, blink_q;
  logic [FW-1:0] frame_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_curs_q <= 1'b0; d_curs_q <= 1'b0; vs_prev_q <= 1'b0; blink_q <= 1'b0; frame_q <= '0;
    end else begin
      if (dot == 3'd0) f_curs_q <= (cursor_col_i == cell_col) && ({5'b0, cursor_row_i} == cell_row);
      if (dot == 3'd7) d_curs_q <= f_curs_q;
      vs_prev_q <= vs_q;
      if (vs_q && !vs_prev_q) begin
        if (frame_q == FW'(BLINK_FRAMES - 1)) begin
          frame_q <= '0;
          blink_q <= ~blink_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    fg_idx = d_attr_q[3:0];
    bg_idx = d_attr_q[7:4];
`ifdef CURSOR_EN
    if (d_curs_q && blink_q) begin
      fg_idx = d_attr_q[7:4];
      bg_idx = d_attr_q[3:0];
    end
`endif
    rgb_d = d_vis_q ? palette(d_glyph_q[dot] ? fg_idx : bg_idx) : 12'h000;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vram_addr_q <= '0; vram_rd_q <= 1'b0; f_off_q <= '0; f_grow_q <= '0;
      f_vis_q <= 1'b0; f_hs_q <= 1'b0; f_vs_q <= 1'b0; f_range_q <= 1'b0;
      f_glyph_q <= '0; f_attr_q <= '0; d_glyph_q <= '0; d_attr_q <= '0;
      d_vis_q <= 1'b0; d_hs_q <= 1'b0; d_vs_q <= 1'b0;
      rgb_q <= '0; hs_q <= 1'b0; vs_q <= 1'b0;
    end else begin
      vram_addr_q <= vram_addr_d;
      vram_rd_q   <= vram_rd_d;
      case (dot)
        3'd0: begin
          f_off_q <= cell_off; f_grow_q <= grow; f_range_q <= in_range;
          f_vis_q <= in_visible_i; f_hs_q <= in_hsync_i; f_vs_q <= in_vsync_i;
        end
        3'd4: f_glyph_q <= vram_data_i;
        3'd6: f_attr_q <= vram_data_i;
        3'd7: begin
          d_glyph_q <= f_glyph_q; d_attr_q <= f_attr_q; d_vis_q <= f_vis_q & f_range_q;
          d_hs_q <= f_hs_q; d_vs_q <= f_vs_q;
        end
        default: ;
      endcase
      rgb_q <= rgb_d;
      hs_q  <= d_hs_q;
      vs_q  <= d_vs_q;
    end
  end

  assign vram_addr_o = vram_addr_q;
  assign vram_rd_o   = vram_rd_q;
  assign r_o         = rgb_q[11:8];
  assign g_o         = rgb_q[7:4];
  assign b_o         = rgb_q[3:0];
  assign hsync_o     = hs_q;
  assign vsync_o     = vs_q;

endmodule

// File: tb/tb_vdp_text.sv
// Bench for vdp_text: directed fetch/pixel vectors, then raster scans with random VRAM
// checked against a per-pixel reference model (pixel n derives from the input 9 clocks earlier).
module tb_vdp_text;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  column, line;
  logic        vis_in, hs_in, vs_in;
  logic [15:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [3:0]  r, g, b;
  logic        hs_out, vs_out;
`ifdef CURSOR_EN
  localparam int BLINK = 2;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
`endif

`ifdef CURSOR_EN
  vdp_text #(.BLINK_FRAMES(BLINK)) dut (
`else
  vdp_text dut (
`endif
    .clk_i(clk), .rst_ni(rst_n), .column_i(column), .line_i(line),
    .in_visible_i(vis_in), .in_hsync_i(hs_in), .in_vsync_i(vs_in),
    .vram_addr_o(vram_addr), .vram_rd_o(vram_rd), .vram_data_i(vram_data),
    .r_o(r), .g_o(g), .b_o(b), .hsync_o(hs_out), .vsync_o(vs_out)
`ifdef CURSOR_EN
    , .cursor_col_i(cur_col), .cursor_row_i(cur_row)
`endif
  );

  logic [7:0] mem [0:65535];
  always @(posedge clk) vram_data <= mem[vram_addr];

  logic [11:0] pal [16];
  int total = 0, bad = 0;

  localparam int HN = 32;
  logic [9:0] h_col [HN];
  logic [9:0] h_line [HN];
  bit h_vis [HN], h_hs [HN], h_vs [HN], h_rok [HN];
  int h_fr [HN];
  int h_ccol [HN], h_crow [HN];
  int cyc = 0, fr = 0;
  bit pvs = 0, model_on = 0;

  typedef struct {
    logic [9:0] col; logic [9:0] ln; logic [15:0] addr; logic rd; logic [11:0] rgb; bit chk_rgb;
  } vec_t;
  vec_t tv [$];

  task automatic check_model(input int n);
    logic [11:0] e_rgb, a_rgb;
    logic e_hs, e_vs, e_rd;
    logic [7:0] code, glyph, attr;
    logic [3:0] fg, bg, t;
    int j, k, m, p, col, sl, row, gr;
    bit ok;
    e_rgb = 0; e_hs = 0; e_vs = 0; e_rd = 0;
    j = n - 9;
    ok = (j >= 0);
    k = 0; m = 0;
    if (ok) begin
      k = int'(h_col[j % HN][2:0]);
      m = j - k;
      ok = (m >= 0);
    end
    if (ok) for (int i = m; i <= n; i++) if (!h_rok[i % HN]) ok = 0;
    if (ok) begin
      p = m % HN;
      col = int'(h_col[p]) / 8; sl = int'(h_line[p]) >> 1; row = sl / 8; gr = sl % 8;
      e_hs = h_hs[p]; e_vs = h_vs[p];
      if (h_vis[p] && col < 80 && row < 30) begin
        code  = mem[(32'h6000 + row * 80 + col) & 32'hFFFF];
        glyph = mem[(32'h3000 + int'(code) * 8 + gr) & 32'hFFFF];
        attr  = mem[(32'h7000 + row * 80 + col) & 32'hFFFF];
        fg = attr[3:0]; bg = attr[7:4];
`ifdef CURSOR_EN
        if (col == h_ccol[p] && row == h_crow[p] && ((h_fr[p] / BLINK) % 2) == 1) begin
          t = fg; fg = bg; bg = t;
        end
`endif
        e_rgb = pal[glyph[k] ? fg : bg];
      end
    end
    if (n >= 1 && h_rok[(n - 1) % HN] && h_rok[n % HN])
      e_rd = (h_col[(n - 1) % HN][2:0] inside {3'd0, 3'd2, 3'd4});
    a_rgb = {r, g, b};
    total++;
    if (a_rgb !== e_rgb || hs_out !== e_hs || vs_out !== e_vs || vram_rd !== e_rd) begin
      bad++;
      $display("FAIL pix n=%0d col=%0d line=%0d got rgb=%h hs=%b vs=%b rd=%b want rgb=%h hs=%b vs=%b rd=%b",
               n, h_col[n % HN], h_line[n % HN], a_rgb, hs_out, vs_out, vram_rd, e_rgb, e_hs, e_vs, e_rd);
    end
  endtask

  task automatic drive(input logic [9:0] c, input logic [9:0] l, input bit v, input bit hsi,
                       input bit vsi, input bit rn);
    int idx;
    @(posedge clk);
    #1;
    column = c; line = l; vis_in = v; hs_in = hsi; vs_in = vsi; rst_n = rn;
    idx = cyc % HN;
    h_col[idx] = c; h_line[idx] = l; h_vis[idx] = v; h_hs[idx] = hsi; h_vs[idx] = vsi; h_rok[idx] = rn;
    if (!rn) begin
      fr = 0; pvs = 0;
    end else if (c[2:0] == 3'd0) begin
      if (vsi && !pvs) fr++;
      pvs = vsi;
    end
    h_fr[idx] = fr;
`ifdef CURSOR_EN
    h_ccol[idx] = int'(cur_col); h_crow[idx] = int'(cur_row);
`else
    h_ccol[idx] = -1; h_crow[idx] = -1;
`endif
    @(negedge clk);
    if (model_on) check_model(cyc);
    cyc++;
  endtask

  // One 800-dot raster line; visible 0..639, hsync 600..695, vsync on lines 490-491.
  task automatic scan_line(input int ln, input bit force_vis, input int rst_col);
    int first, cnt;
    bit v, rn;
    first = -1; cnt = 0;
    for (int c = 0; c < 800; c++) begin
      v  = force_vis ? 1'b1 : (c < 640 && ln < 480);
      rn = !(rst_col >= 0 && c >= rst_col && c < rst_col + 3);
      drive(10'(c), 10'(ln), v, (c >= 600 && c < 696), (ln >= 490 && ln < 492), rn);
      if (hs_out === 1'b1) begin
        if (first < 0) first = c;
        cnt++;
      end
      if (c == rst_col) begin
        total++;
        if (vram_addr !== 16'h0 || vram_rd !== 1'b0 || {r, g, b} !== 12'h0 || hs_out !== 1'b0 || vs_out !== 1'b0) begin
          bad++;
          $display("FAIL rst_async got addr=%h rd=%b rgb=%h hs=%b vs=%b want all zero",
                   vram_addr, vram_rd, {r, g, b}, hs_out, vs_out);
        end
      end
    end
    if (rst_col < 0) begin
      total++;
      if (first != 609 || cnt != 96) begin
        bad++;
        $display("FAIL hsync_timing line=%0d got start=%0d width=%0d want start=609 width=96", ln, first, cnt);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; column = '0; line = '0; vis_in = 0; hs_in = 0; vs_in = 0;
`ifdef CURSOR_EN
    cur_col = 7'd127; cur_row = 5'd31;
`endif
    pal[0] = 12'h000; pal[1] = 12'h00A; pal[2] = 12'h0A0; pal[3] = 12'h0AA;
    pal[4] = 12'hA00; pal[5] = 12'hA0A; pal[6] = 12'hA50; pal[7] = 12'hAAA;
    pal[8] = 12'h555; pal[9] = 12'h55F; pal[10] = 12'h5F5; pal[11] = 12'h5FF;
    pal[12] = 12'hF55; pal[13] = 12'hF5F; pal[14] = 12'hFF5; pal[15] = 12'hFFF;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h6000] = 8'h41; mem[16'h7000] = 8'h1E; mem[16'h3208] = 8'h03;
    mem[16'h7001] = 8'h5C; mem[16'h6051] = 8'h7F; mem[16'h60A2] = 8'h10;

    // {column, line, vram_addr, vram_rd, rgb, check rgb}; outputs reflect the previous clock edge.
    tv.push_back('{10'd0, 10'd0, 16'h0000, 1'b0, 12'h000, 1'b1});
    tv.push_back('{10'd1, 10'd0, 16'h6000, 1'b1, 12'h000, 1'b1});
    tv.push_back('{10'd2, 10'd0, 16'h6000, 1'b0, 12'h000, 1'b1});
    tv.push_back('{10'd3, 10'd0, 16'h3208, 1'b1, 12'h000, 1'b1});
    tv.push_back('{10'd4, 10'd0, 16'h3208, 1'b0, 12'h000, 1'b1});
    tv.push_back('{10'd5, 10'd0, 16'h7000, 1'b1, 12'h000, 1'b1});
    tv.push_back('{10'd6, 10'd0, 16'h7000, 1'b0, 12'h000, 1'b1});
    tv.push_back('{10'd7, 10'd0, 16'h7000, 1'b0, 12'h000, 1'b1});
    tv.push_back('{10'd8, 10'd0, 16'h7000, 1'b0, 12'h000, 1'b1});
    tv.push_back('{10'd9, 10'd0, 16'h6001, 1'b1, 12'hFF5, 1'b1});
    tv.push_back('{10'd10, 10'd0, 16'h6001, 1'b0, 12'hFF5, 1'b1});
    tv.push_back('{10'd11, 10'd0, 16'h3000, 1'b1, 12'h00A, 1'b1});
    tv.push_back('{10'd12, 10'd0, 16'h3000, 1'b0, 12'h00A, 1'b1});
    tv.push_back('{10'd13, 10'd0, 16'h7001, 1'b1, 12'h00A, 1'b1});
    tv.push_back('{10'd14, 10'd0, 16'h7001, 1'b0, 12'h00A, 1'b1});
    tv.push_back('{10'd15, 10'd0, 16'h7001, 1'b0, 12'h00A, 1'b1});
    tv.push_back('{10'd16, 10'd0, 16'h7001, 1'b0, 12'h00A, 1'b1});
    tv.push_back('{10'd17, 10'd0, 16'h6002, 1'b1, 12'hA0A, 1'b1});
    // line 18: text row 1, glyph row 1
    tv.push_back('{10'd8, 10'd18, 16'h6002, 1'b0, 12'h000, 1'b0});
    tv.push_back('{10'd9, 10'd18, 16'h6051, 1'b1, 12'h000, 1'b0});
    tv.push_back('{10'd10, 10'd18, 16'h6051, 1'b0, 12'h000, 1'b0});
    tv.push_back('{10'd11, 10'd18, 16'h33F9, 1'b1, 12'h000, 1'b0});
    tv.push_back('{10'd12, 10'd18, 16'h33F9, 1'b0, 12'h000, 1'b0});
    tv.push_back('{10'd13, 10'd18, 16'h7051, 1'b1, 12'h000, 1'b0});
    tv.push_back('{10'd14, 10'd18, 16'h7051, 1'b0, 12'h000, 1'b0});
    tv.push_back('{10'd15, 10'd18, 16'h7051, 1'b0, 12'h000, 1'b0});
    // line 34: (34>>1)=17 -> text row 2, glyph row 1
    tv.push_back('{10'd16, 10'd34, 16'h7051, 1'b0, 12'h000, 1'b0});
    tv.push_back('{10'd17, 10'd34, 16'h60A2, 1'b1, 12'h000, 1'b0});
    tv.push_back('{10'd18, 10'd34, 16'h60A2, 1'b0, 12'h000, 1'b0});
    tv.push_back('{10'd19, 10'd34, 16'h3081, 1'b1, 12'h000, 1'b0});
    tv.push_back('{10'd20, 10'd34, 16'h3081, 1'b0, 12'h000, 1'b0});

    drive(10'd797, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(10'd798, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].col, tv[i].ln, 1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (vram_addr !== tv[i].addr || vram_rd !== tv[i].rd) begin
        bad++;
        $display("FAIL fetch step=%0d got addr=%h rd=%b want addr=%h rd=%b",
                 i, vram_addr, vram_rd, tv[i].addr, tv[i].rd);
      end
      if (tv[i].chk_rgb) begin
        total++;
        if ({r, g, b} !== tv[i].rgb) begin
          bad++;
          $display("FAIL pixel step=%0d got rgb=%h want rgb=%h", i, {r, g, b}, tv[i].rgb);
        end
      end
    end

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    model_on = 1;
    for (int c = 797; c < 800; c++) drive(10'(c), 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    scan_line(0, 0, -1);
    scan_line(1, 0, -1);
    scan_line(17, 0, -1);
    scan_line(238, 0, -1);
    scan_line(479, 0, -1);
    scan_line(480, 1, -1);
    scan_line(5, 1, -1);
    scan_line(490, 0, -1);
    scan_line(100, 0, 300);
    scan_line(2, 0, -1);

`ifdef CURSOR_EN
    mem[16'h7000] = 8'h1E;
    cur_col = 7'd0; cur_row = 5'd0;
    for (int c = 797; c < 800; c++) drive(10'(c), 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      scan_line(0, 0, -1);
      scan_line(490, 0, -1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
